gauss1d_stream: RTL and testbench
=================================

// Module: gauss1d_stream
// PURPOSE
//  Streaming 1-D binomial (Gaussian) filter, successor to the fixed 3-tap window filter.
//  Builds its own KSIZE-tap window from a pixel/event stream with valid/ready backpressure,
//  replicates the border sample at line start/end, and optionally normalises the output.
//  Sits between the event/pixel source and downstream 2-D/threshold stages.
// PARAMETERS
//  DATA_WIDTH  14  input sample width, unsigned
//  KSIZE       3   tap count, 3 (1 2 1) or 5 (1 4 6 4 1); any other value is an elaboration error
//  OUT_WIDTH   DATA_WIDTH+KSIZE-1  localparam, full-precision sum width (coefficient sum = 2^(KSIZE-1))
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           reset, asynchronous, active-low
//  cfg_norm   in   1           1: out = (sum + 2^(KSIZE-2)) >> (KSIZE-1), zero-extended; 0: raw sum
//  in_valid   in   1           input sample valid
//  in_ready   out  1           block accepts sample this cycle
//  in_data    in   DATA_WIDTH  input sample
//  in_last    in   1           marks the last sample of a line
//  out_valid  out  1           output valid
//  out_ready  in   1           downstream accepts output
//  out_data   out  OUT_WIDTH   filtered sample
//  out_last   out  1           marks the last output of a line
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_last=0, window=0, wait=0, state=IDLE; in_ready is combinational.
//  - HALF=(KSIZE-1)/2. Window win[0..KSIZE-1], win[KSIZE-1] newest; centre win[HALF].
//  - adv = !out_valid || out_ready. in_ready = adv && state!=FLUSH. Accept = in_valid && in_ready.
//  - IDLE: accept loads all window entries with in_data, wait=HALF, no output;
//    -> FLUSH (flush_cnt=HALF) if in_last, else -> RUN.
//  - RUN: accept shifts in_data into window (shift); in_last -> FLUSH, flush_cnt=HALF.
//  - FLUSH: each cycle with adv: shift in copy of win[KSIZE-1], flush_cnt--; at 0 -> IDLE.
//  - Every shift: if wait>0 then wait--; emit iff wait==0 after update. Emit = on the same edge,
//    out_data <= weighted sum of post-shift window (norm applied per cfg_norm), out_valid<=1,
//    out_last <= (final FLUSH shift). No emit with adv -> out_valid<=0.
//  - Exactly L outputs per line of L samples (L>=1, incl. L<HALF+1); out_last only on the L-th.
//  - Latency: output j valid the cycle after acceptance of sample j+HALF (or matching flush shift).
//  - Backpressure: out_valid && !out_ready holds out_data/out_last/window/state; no loss, no dup.
//  - Output consumed and new sample accepted same cycle: full throughput, no bubble.
//  - in_ready=0 throughout FLUSH (HALF cycles per line of dead input time, by design).
//  - cfg_norm static within a line; sampled at each emit edge.
//  - Normalised result cannot exceed 2^DATA_WIDTH-1; raw sum max = (2^DATA_WIDTH-1)*2^(KSIZE-1), fits OUT_WIDTH.
//  - Reset mid-line: everything cleared; next accepted sample is first of a new line.
// STRUCTURE
//  - gauss_pkg: state enum {IDLE,RUN,FLUSH}, binomial coefficient function coef(KSIZE,i),
//    width helper out_width(DATA_WIDTH,KSIZE).
//  - Sub-module gauss_win_sum: combinational weighted sum + optional rounding shift of a
//    packed KSIZE*DATA_WIDTH window; shift-add only, no multipliers.
//  - Top: window shift register, wait/flush counters, FSM, output register.
// TESTING
//  1 K=3, norm=0, line 10,20,30,40(last) -> 50,80,120,150; out_last on 150 only.
//  2 Same line, norm=1 -> 13,20,30,38.
//  3 K=5, norm=0, single sample 100 with in_last -> one output 1600, out_last=1; norm=1 -> 100.
//  4 K=5, DATA_WIDTH=14, line of 8 x 16383 -> 8 x 262128 (norm=1: 16383); no overflow.
//  5 K=3, out_ready low 5 cycles mid-line -> in_ready low, out_data stable, sequence unchanged.
//  6 rst_n pulse after 2 of 4 samples, then 5,5(last) -> outputs 20,20 only; back-to-back lines
//    with in_valid held high -> in_ready low for exactly HALF cycles between lines.

Source files
------------

// File: rtl/gauss_pkg.sv
// Shared types and elaboration-time helpers for the 1-D binomial filter.
package gauss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Binomial coefficient C(ksize-1, i): row ksize-1 of Pascal's triangle.
    function automatic int coef(input int ksize, input int i);
        int c;
        c = 1;
        for (int k = 0; k < i; k++) begin
            c = c * (ksize - 1 - k) / (k + 1);
        end
        return c;
    endfunction

    // Full-precision sum width: coefficients add up to 2^(ksize-1).
    function automatic int out_width(input int data_width, input int ksize);
        return data_width + ksize - 1;
    endfunction

endpackage

// File: rtl/gauss_win_sum.sv
// Weighted binomial sum of a packed window, built from shifts and adds only,
// with an optional round-to-nearest normalisation back to the input range.
module gauss_win_sum
    import gauss_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int KSIZE      = 3,
    localparam int OUT_WIDTH = out_width(DATA_WIDTH, KSIZE)
) (
    input  logic [KSIZE*DATA_WIDTH-1:0] win,
    input  logic                        norm,
    output logic [OUT_WIDTH-1:0]        sum
);

    localparam logic [OUT_WIDTH-1:0] ROUND = OUT_WIDTH'(1) << (KSIZE - 2);

    logic [OUT_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]  rounded;
    logic [DATA_WIDTH-1:0] tap;

    // Accumulate each tap once per set bit of its (constant) coefficient.
    always_comb begin
        acc = '0;
        tap = '0;
        for (int i = 0; i < KSIZE; i++) begin
            tap = win[i*DATA_WIDTH +: DATA_WIDTH];
            for (int b = 0; b < KSIZE; b++) begin
                if (((coef(KSIZE, i) >> b) & 1) == 1) begin
                    acc = acc + (OUT_WIDTH'(tap) << b);
                end
            end
        end
    end

    // Round half up, then divide by the coefficient sum; upper bits end up zero.
    always_comb begin
        rounded = (acc + ROUND) >> (KSIZE - 1);
        sum     = norm ? rounded : acc;
    end

endmodule

// File: rtl/gauss1d_stream.sv
// Streaming 1-D binomial filter with valid/ready handshakes on both sides.
// Each line is border-replicated: the first sample fills the whole window and
// the last sample is repeated HALF times during FLUSH, so a line of L samples
// always yields exactly L outputs.
module gauss1d_stream
    import gauss_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int KSIZE      = 3,
    localparam int OUT_WIDTH = out_width(DATA_WIDTH, KSIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_norm,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last
);

    localparam int HALF = (KSIZE - 1) / 2;
    localparam int CW   = $clog2(HALF + 1);
    localparam int WW   = KSIZE * DATA_WIDTH;

    generate
        if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
            $error("gauss1d_stream: KSIZE must be 3 or 5");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [CW-1:0]         flush_q, flush_d;
    logic [WW-1:0]         win_q, win_d;
    logic [DATA_WIDTH-1:0] newest;
    logic [DATA_WIDTH-1:0] shift_val;
    logic                  shift_en;
    logic                  final_shift;
    logic                  adv;
    logic                  accept;
    logic                  emit;
    logic [OUT_WIDTH-1:0]  sum;

    // Handshake: the pipeline advances whenever the output register is free.
    always_comb begin
        newest   = win_q[WW-1 -: DATA_WIDTH];
        adv      = !out_valid || out_ready;
        in_ready = adv && (state_q != FLUSH);
        accept   = in_valid && in_ready;
    end

    // Next state, window load/shift and warm-up/flush counting.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        flush_d     = flush_q;
        win_d       = win_q;
        shift_en    = 1'b0;
        shift_val   = in_data;
        final_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    win_d  = {KSIZE{in_data}};
                    wait_d = CW'(HALF);
                    if (in_last) begin
                        state_d = FLUSH;
                        flush_d = CW'(HALF);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    shift_en  = 1'b1;
                    shift_val = in_data;
                    if (in_last) begin
                        state_d = FLUSH;
                        flush_d = CW'(HALF);
                    end
                end
            end
            FLUSH: begin
                if (adv) begin
                    shift_en  = 1'b1;
                    shift_val = newest;
                    flush_d   = flush_q - CW'(1);
                    if (flush_q == CW'(1)) begin
                        state_d     = IDLE;
                        final_shift = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (shift_en) begin
            win_d = {shift_val, win_q[WW-1 -: (KSIZE-1)*DATA_WIDTH]};
            if (wait_q != '0) begin
                wait_d = wait_q - CW'(1);
            end
        end
        emit = shift_en && (wait_d == '0);
    end

    gauss_win_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .KSIZE      (KSIZE)
    ) u_sum (
        .win  (win_d),
        .norm (cfg_norm),
        .sum  (sum)
    );

    // Control state and window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            flush_q <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flush_q <= flush_d;
            win_q   <= win_d;
        end
    end

    // Output register: load on emit, drop valid when advancing without one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= sum;
                out_last  <= final_shift;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gauss1d_stream.sv
// Self-checking bench for gauss1d_stream: one KSIZE=3 and one KSIZE=5 instance,
// driven line by line and compared against a clamped-index convolution model.
module tb_gauss1d_stream;

    logic        clk;
    logic        rst_n;
    logic        cfg_norm;
    logic        in_valid3, in_valid5;
    logic [13:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        in_ready3, in_ready5;
    logic        out_valid3, out_valid5;
    logic [15:0] out_data3;
    logic [17:0] out_data5;
    logic        out_last3, out_last5;

    logic        sel5;
    logic        cur_in_valid, cur_in_ready, cur_out_valid, cur_out_last;
    logic [17:0] cur_out_data;

    int checks   = 0;
    int failures = 0;

    int smp[$];
    bit lst[$];
    longint exp_q[$];
    bit exp_last_q[$];

    gauss1d_stream #(.DATA_WIDTH(14), .KSIZE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_norm(cfg_norm),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_last(out_last3)
    );

    gauss1d_stream #(.DATA_WIDTH(14), .KSIZE(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .cfg_norm(cfg_norm),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5), .out_last(out_last5)
    );

    assign cur_in_valid  = sel5 ? in_valid5  : in_valid3;
    assign cur_in_ready  = sel5 ? in_ready5  : in_ready3;
    assign cur_out_valid = sel5 ? out_valid5 : out_valid3;
    assign cur_out_last  = sel5 ? out_last5  : out_last3;
    assign cur_out_data  = sel5 ? out_data5  : {2'b00, out_data3};

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void clear_stream();
        smp.delete();
        lst.delete();
    endfunction

    function automatic void add_sample(input int v, input bit last);
        smp.push_back(v);
        lst.push_back(last);
    endfunction

    function automatic void add_random_line(input int len);
        for (int i = 0; i < len; i++) begin
            add_sample($urandom_range(0, 16383), (i == len - 1));
        end
    endfunction

    // Reference: out[j] = sum_i c[i] * x[clamp(j - HALF + i)] over each line.
    function automatic void build_expected(input int k, input bit norm);
        int c[5];
        int half;
        int start;
        half  = (k - 1) / 2;
        start = 0;
        if (k == 3) c = '{1, 2, 1, 0, 0};
        else        c = '{1, 4, 6, 4, 1};
        exp_q.delete();
        exp_last_q.delete();
        for (int p = 0; p < smp.size(); p++) begin
            if (lst[p]) begin
                int len;
                len = p - start + 1;
                for (int j = 0; j < len; j++) begin
                    longint s;
                    s = 0;
                    for (int i = 0; i < k; i++) begin
                        int pos;
                        pos = j - half + i;
                        if (pos < 0) pos = 0;
                        if (pos > len - 1) pos = len - 1;
                        s += c[i] * smp[start + pos];
                    end
                    if (norm) s = (s + (1 << (k - 2))) / (1 << (k - 1));
                    exp_q.push_back(s);
                    exp_last_q.push_back(j == len - 1);
                end
                start = p + 1;
            end
        end
    endfunction

    task automatic run_stream(input int k, input bit norm, input int stall_pct, input int gap_pct,
                              input int force_at, input int force_len, output int blocked);
        int idx;
        int cyc;
        bit was_stalled;
        bit forced;
        logic [17:0] held_data;
        logic held_last;
        idx = 0;
        cyc = 0;
        was_stalled = 0;
        held_data = '0;
        held_last = 0;
        blocked = 0;
        sel5 = (k == 5);
        cfg_norm = norm;
        build_expected(k, norm);
        while (exp_q.size() > 0 && cyc < 5000) begin
            @(negedge clk);
            forced = (cyc >= force_at) && (cyc < force_at + force_len);
            out_ready = forced ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
            in_valid3 = 0;
            in_valid5 = 0;
            in_last = 0;
            in_data = '0;
            if (idx < smp.size() && $urandom_range(0, 99) >= gap_pct) begin
                in_data = 14'(smp[idx]);
                in_last = lst[idx];
                if (k == 5) in_valid5 = 1;
                else        in_valid3 = 1;
            end
            #1;
            if (was_stalled) begin
                check_output("hold_valid", 64'(cur_out_valid), 64'd1);
                check_output("hold_data", 64'(cur_out_data), 64'(held_data));
                check_output("hold_last", 64'(cur_out_last), 64'(held_last));
            end
            if (forced && cur_out_valid) check_output("stall_in_ready", 64'(cur_in_ready), 64'd0);
            if (cur_out_valid && out_ready) begin
                check_output("out_data", 64'(cur_out_data), 64'(exp_q.pop_front()));
                check_output("out_last", 64'(cur_out_last), 64'(exp_last_q.pop_front()));
            end
            was_stalled = cur_out_valid && !out_ready;
            held_data = cur_out_data;
            held_last = cur_out_last;
            if (cur_in_valid && !cur_in_ready) blocked++;
            if (cur_in_valid && cur_in_ready) idx++;
            cyc++;
        end
        check_output("outputs_missing", 64'(exp_q.size()), 64'd0);
        check_output("inputs_unconsumed", 64'(smp.size() - idx), 64'd0);
        @(negedge clk);
        in_valid3 = 0;
        in_valid5 = 0;
        out_ready = 1;
        #1;
        check_output("no_extra_output", 64'(cur_out_valid), 64'd0);
    endtask

    initial begin
        int blk;
        int got;
        int cyc;
        clk = 0;
        rst_n = 0;
        cfg_norm = 0;
        in_valid3 = 0;
        in_valid5 = 0;
        in_data = '0;
        in_last = 0;
        out_ready = 1;
        sel5 = 0;
        apply_reset();

        #1;
        for (int s = 0; s < 2; s++) begin
            sel5 = (s == 1);
            #1;
            check_output("rst_out_valid", 64'(cur_out_valid), 64'd0);
            check_output("rst_out_data", 64'(cur_out_data), 64'd0);
            check_output("rst_out_last", 64'(cur_out_last), 64'd0);
            check_output("rst_in_ready", 64'(cur_in_ready), 64'd1);
        end

        $display("[TB] K=3 basic line, raw and normalised");
        clear_stream();
        add_sample(10, 0); add_sample(20, 0); add_sample(30, 0); add_sample(40, 1);
        run_stream(3, 0, 0, 0, 0, 0, blk);
        run_stream(3, 1, 0, 0, 0, 0, blk);

        $display("[TB] K=5 single-sample line");
        clear_stream();
        add_sample(100, 1);
        run_stream(5, 0, 0, 0, 0, 0, blk);
        run_stream(5, 1, 0, 0, 0, 0, blk);

        $display("[TB] K=5 full-scale line");
        clear_stream();
        for (int i = 0; i < 8; i++) add_sample(16383, (i == 7));
        run_stream(5, 0, 0, 0, 0, 0, blk);
        run_stream(5, 1, 0, 0, 0, 0, blk);

        $display("[TB] K=3 output stall mid-line");
        clear_stream();
        add_random_line(12);
        run_stream(3, 0, 0, 0, 6, 5, blk);

        $display("[TB] reset mid-line");
        sel5 = 0;
        cfg_norm = 0;
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 50) begin
            @(negedge clk);
            out_ready = 1;
            in_valid3 = 1;
            in_last = 0;
            in_data = 14'(1000 + 100 * got);
            #1;
            if (in_ready3) got++;
            cyc++;
        end
        check_output("pre_reset_accepts", 64'(got), 64'd2);
        @(negedge clk);
        in_valid3 = 0;
        rst_n = 0;
        #1;
        check_output("mid_rst_out_valid", 64'(out_valid3), 64'd0);
        check_output("mid_rst_out_data", 64'(out_data3), 64'd0);
        @(negedge clk);
        rst_n = 1;
        clear_stream();
        add_sample(5, 0); add_sample(5, 1);
        run_stream(3, 0, 0, 0, 0, 0, blk);

        $display("[TB] back-to-back lines with in_valid held high");
        clear_stream();
        add_random_line(4); add_random_line(1); add_random_line(6);
        run_stream(3, 0, 0, 0, 0, 0, blk);
        check_output("gap_k3", 64'(blk), 64'd2);
        run_stream(5, 1, 0, 0, 0, 0, blk);
        check_output("gap_k5", 64'(blk), 64'd4);

        $display("[TB] randomized lines with stalls and gaps");
        for (int r = 0; r < 4; r++) begin
            clear_stream();
            for (int l = 0; l < 6; l++) add_random_line($urandom_range(1, 9));
            run_stream((r < 2) ? 3 : 5, r[0], 30, 20, 0, 0, blk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
